// File: rtl/img2col_patch_packer.sv
// img2col_patch_packer: takes the im2col address stream, issues SRAM reads,
// parks the returning pixels in a credit-guarded FIFO and packs every
// K_R*K_S pixels into one patch for the systolic array's Matrix-B port.

// Overflow watchdog: the credit accounting must never let a push land on a
// full pixel FIFO.
module img2col_patch_packer_chk (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic push,
  input logic full
);

  property p_no_fifo_overflow;
    @(posedge clk) disable iff (!rst_n) !(push && full && !start);
  endproperty

  a_no_fifo_overflow: assert property (p_no_fifo_overflow);

endmodule

module img2col_patch_packer #(
  parameter int DATA_W      = 8,
  parameter int SRAM_ADDR_W = 10,
  parameter int K_R         = 5,
  parameter int K_S         = 5,
  parameter int OUT_W       = 24,
  parameter int OUT_H       = 24,
  parameter int RD_LAT      = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_async_n_i,
  input  logic                        start_i,
  input  logic                        addr_valid_i,
  input  logic [SRAM_ADDR_W-1:0]      addr_i,
  output logic                        addr_ready_o,
  output logic                        sram_rd_en_o,
  output logic [SRAM_ADDR_W-1:0]      sram_rd_addr_o,
  input  logic [DATA_W-1:0]           sram_rd_data_i,
  output logic                        patch_valid_o,
  output logic [DATA_W*K_R*K_S-1:0]   patch_data_o,
  output logic                        patch_last_o,
  input  logic                        patch_ready_i,
  output logic                        busy_o
);

  localparam int NPIX    = K_R * K_S;
  localparam int NPATCH  = OUT_W * OUT_H;
  localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PATCH_W = (NPATCH > 1) ? $clog2(NPATCH) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;
  localparam int CRED_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(NPIX - 1);
  localparam logic [PATCH_W-1:0] PATCH_LAST = PATCH_W'(NPATCH - 1);
  localparam logic [CRED_W-1:0]  CRED_MAX   = CRED_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 ready_en_r;
  logic [CRED_W-1:0]    credit_r;
  logic [RD_LAT-1:0]    inflight_r;
  logic [DATA_W-1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [DATA_W-1:0]    fifo_rd_data_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic                 acc_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 hs_s;
  logic [PIX_W-1:0]     pix_cnt_r;
  logic [PATCH_W-1:0]   patch_cnt_r;
  logic                 busy_r;
  logic [DATA_W-1:0]    patch_r [NPIX];

  // Generator-facing handshake and zero-latency SRAM issue; ready is held
  // low through reset and the cycle after, and while a new image starts.
  assign addr_ready_o   = ready_en_r & ~start_i & (credit_r != {CRED_W{1'b0}});
  assign acc_s          = addr_valid_i & addr_ready_o;
  assign sram_rd_en_o   = acc_s;
  assign sram_rd_addr_o = addr_i;

  // Return path: the oldest in-flight bit marks the cycle the data is live.
  assign push_s         = inflight_r[RD_LAT-1];
  assign fifo_empty_s   = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) & (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign fifo_rd_data_s = fifo_mem_r[rd_ptr_r[AW-1:0]];

  assign patch_valid_o  = (state_r == HOLD);
  assign patch_last_o   = patch_valid_o & (patch_cnt_r == PATCH_LAST);
  assign busy_o         = busy_r;

  for (genvar gi = 0; gi < NPIX; gi++) begin : g_patch_out
    assign patch_data_o[gi*DATA_W +: DATA_W] = patch_r[gi];
  end

  // Ready enable: comes up one clock after reset release.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // In-flight tracker: one bit per outstanding read, shifted once per cycle.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      inflight_r <= {RD_LAT{1'b0}};
    end else if (start_i) begin
      inflight_r <= {RD_LAT{1'b0}};
    end else begin
      inflight_r <= (inflight_r << 1'b1) | RD_LAT'(acc_s);
    end
  end

  // Credit counter: a handshake takes a slot, a FIFO pop gives it back.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      credit_r <= CRED_MAX;
    end else if (start_i) begin
      credit_r <= CRED_MAX;
    end else begin
      case ({acc_s, pop_s})
        2'b10:   credit_r <= credit_r - CRED_W'(1);
        2'b01:   credit_r <= credit_r + CRED_W'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else if (start_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // FIFO storage: capture returning SRAM data at the write pointer.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s && !start_i) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= sram_rd_data_i;
    end
  end

  // Packer state register.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Packer next state: FILL pops whenever data is waiting; HOLD only pops
  // in the handshake cycle so the accepted patch stays visible until then.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    hs_s        = 1'b0;
    if (start_i) begin
      state_nxt_s = FILL;
    end else begin
      case (state_r)
        FILL: begin
          if (!fifo_empty_s) begin
            pop_s = 1'b1;
            if (pix_cnt_r == PIX_LAST) begin
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = FILL;
            end
          end else begin
            state_nxt_s = FILL;
          end
        end
        HOLD: begin
          if (patch_ready_i) begin
            hs_s  = 1'b1;
            pop_s = ~fifo_empty_s;
            if (!fifo_empty_s && (pix_cnt_r == PIX_LAST)) begin
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = FILL;
            end
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s = FILL;
        end
      endcase
    end
  end

  // Pixel slot counter, wraps after the last slot of a patch.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      pix_cnt_r <= {PIX_W{1'b0}};
    end else if (start_i) begin
      pix_cnt_r <= {PIX_W{1'b0}};
    end else if (pop_s) begin
      if (pix_cnt_r == PIX_LAST) begin
        pix_cnt_r <= {PIX_W{1'b0}};
      end else begin
        pix_cnt_r <= pix_cnt_r + PIX_W'(1);
      end
    end
  end

  // Patch index within the image, advanced on every accepted patch.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      patch_cnt_r <= {PATCH_W{1'b0}};
    end else if (start_i) begin
      patch_cnt_r <= {PATCH_W{1'b0}};
    end else if (hs_s) begin
      if (patch_cnt_r == PATCH_LAST) begin
        patch_cnt_r <= {PATCH_W{1'b0}};
      end else begin
        patch_cnt_r <= patch_cnt_r + PATCH_W'(1);
      end
    end
  end

  // Busy flag: raised by start, dropped after the final patch is taken.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      busy_r <= 1'b0;
    end else if (start_i) begin
      busy_r <= 1'b1;
    end else if (hs_s && patch_last_o) begin
      busy_r <= 1'b0;
    end
  end

  // Patch register: each pop lands in the slot named by the pixel counter.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      for (int i = 0; i < NPIX; i++) begin
        patch_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        if (pop_s && (pix_cnt_r == PIX_W'(i))) begin
          patch_r[i] <= fifo_rd_data_s;
        end
      end
    end
  end

  img2col_patch_packer_chk u_chk (
    .clk   (clk_i),
    .rst_n (rst_async_n_i),
    .start (start_i),
    .push  (push_s),
    .full  (fifo_full_s)
  );

endmodule
